// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounced hex key output
//
// Ports:
//   Clock    - system clock, all logic on posedge
//   resetSW  - synchronous active-high reset
//   Row[3:0] - keypad rows, active-low, asynchronous to Clock
//   Col[3:0] - column strobe, active-low one-hot
//   Key[3:0] - hex code of the last accepted key, held after release
//   KeyValid - one-cycle pulse on each newly accepted press
//   KeyHeld  - high while the accepted key is debounced-down
module keypad_scanner #(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       Clock,
    input  logic       resetSW,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] Key,
    output logic       KeyValid,
    output logic       KeyHeld
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    // "cnt + 1 == DEBOUNCE_SCANS" rewritten so the compare never overflows cnt
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASE   = 2'd3
    } state_t;

    // Row synchronizer; resets to the idle (pulled-up) level
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    always_ff @(posedge Clock) begin
        if (resetSW) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= Row;
            row_sync <= row_meta;
        end
    end

    // Prescaler and column index
    logic [PW-1:0] presc;
    logic [1:0]    col_idx;
    logic          tick;

    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge Clock) begin
        if (resetSW) begin
            presc   <= '0;
            col_idx <= 2'd0;
        end else if (tick) begin
            presc   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

    assign Col = ~(4'b0001 << col_idx);

    // Lowest pressed row within the current column
    logic       col_hit;
    logic [1:0] hit_row;
    logic [3:0] col_code;

    always_comb begin
        col_hit = ~&row_sync;
        hit_row = 2'd0;
        if (!row_sync[0])      hit_row = 2'd0;
        else if (!row_sync[1]) hit_row = 2'd1;
        else if (!row_sync[2]) hit_row = 2'd2;
        else if (!row_sync[3]) hit_row = 2'd3;
    end

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    assign col_code = key_map(hit_row, col_idx);

    // Scan accumulator: columns arrive in ascending order, so the first hit
    // kept is automatically the lowest column, lowest row.
    logic       acc_hit;
    logic [3:0] acc_code;
    logic       scan_hit;
    logic [3:0] scan_code;
    logic       scan_done;

    always_ff @(posedge Clock) begin
        if (resetSW) begin
            acc_hit   <= 1'b0;
            acc_code  <= 4'h0;
            scan_hit  <= 1'b0;
            scan_code <= 4'h0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (tick) begin
                if (col_idx == 2'd3) begin
                    scan_hit  <= acc_hit || col_hit;
                    scan_code <= acc_hit ? acc_code : col_code;
                    scan_done <= 1'b1;
                    acc_hit   <= 1'b0;
                    acc_code  <= 4'h0;
                end else if (col_hit && !acc_hit) begin
                    acc_hit   <= 1'b1;
                    acc_code  <= col_code;
                end
            end
        end
    end

    // Debounce FSM, evaluated once per completed scan
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    key_n;
    logic          valid_n;
    logic          match;

    assign match = scan_hit && (scan_code == cand);

    always_ff @(posedge Clock) begin
        if (resetSW) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cand     <= 4'h0;
            Key      <= 4'h0;
            KeyValid <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cand     <= cand_n;
            Key      <= key_n;
            KeyValid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        key_n   = Key;
        valid_n = 1'b0;
        if (scan_done) begin
            case (state)
                ST_IDLE: begin
                    if (scan_hit) begin
                        cand_n  = scan_code;
                        cnt_n   = CNT_ONE;
                        state_n = ST_CANDIDATE;
                    end
                end
                ST_CANDIDATE: begin
                    if (match) begin
                        if (cnt == CNT_LAST) begin
                            key_n   = cand;
                            valid_n = 1'b1;
                            state_n = ST_PRESSED;
                        end else begin
                            cnt_n = cnt + CNT_ONE;
                        end
                    end else if (scan_hit) begin
                        // Different key showed up: restart on the new candidate
                        cand_n = scan_code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    // A different key counts as a release of the accepted one
                    if (!match) begin
                        cnt_n   = CNT_ONE;
                        state_n = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (match) begin
                        state_n = ST_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign KeyHeld = (state == ST_PRESSED) || (state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed scoreboard bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SCAN = 16;

    logic        Clock   = 1'b0;
    logic        resetSW = 1'b1;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [3:0]  Key;
    logic        KeyValid;
    logic        KeyHeld;

    // pressed[4*r + c] models the physical key at row r, column c
    logic [15:0] pressed = 16'h0000;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] key;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .Clock    (Clock),
        .resetSW  (resetSW),
        .Row      (Row),
        .Col      (Col),
        .Key      (Key),
        .KeyValid (KeyValid),
        .KeyHeld  (KeyHeld)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Passive keypad matrix: a row is pulled low when a pressed key in it sits on a driven column
    always_comb begin
        Row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4'(4 * r + c)] && Col[2'(c)] === 1'b0) Row[2'(r)] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic scans(input int n);
        cycles(n * SCAN);
    endtask

    // Every KeyValid pulse must match the oldest queued expectation in cycle and code
    always @(negedge Clock) begin
        if (KeyValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("kv_spurious", 32'(KeyValid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("kv_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("kv_key", 32'(Key), 32'(mon_e.key));
            end
        end
    end

    initial begin
        logic [3:0] exp_col;

        // Reset, then column walk
        resetSW = 1'b1;
        pressed = 16'h0000;
        repeat (3) @(posedge Clock);
        #1;
        resetSW = 1'b0;
        check("reset_col", 32'(Col), 32'h0000_000E);
        check("reset_key", 32'(Key), 32'd0);
        check("reset_kv", 32'(KeyValid), 32'd0);
        check("reset_held", 32'(KeyHeld), 32'd0);
        for (int n = 1; n <= 2 * SCAN; n++) begin
            @(posedge Clock);
            #1;
            if (n % 4 == 2) begin
                exp_col = 4'b0001 << ((n / 4) % 4);
                exp_col = ~exp_col;
                check("col_step", 32'(Col), 32'(exp_col));
            end
        end

        // Clean press of '5' for 6 scans
        pressed[5] = 1'b1;
        sb.push_back('{4'h5, cyc + 3 * SCAN + 1});
        scans(3);
        check("press_held_early", 32'(KeyHeld), 32'd0);
        cycles(1);
        check("press_held", 32'(KeyHeld), 32'd1);
        check("press_key", 32'(Key), 32'h5);
        cycles(SCAN - 1);
        scans(2);
        check("hold_key", 32'(Key), 32'h5);
        check("hold_held", 32'(KeyHeld), 32'd1);

        // One-scan dropout is absorbed
        pressed[5] = 1'b0;
        scans(1);
        pressed[5] = 1'b1;
        cycles(2);
        check("glitch_held_rel", 32'(KeyHeld), 32'd1);
        cycles(SCAN - 2);
        cycles(2);
        check("glitch_held_back", 32'(KeyHeld), 32'd1);
        cycles(SCAN - 2);

        // Real release
        pressed[5] = 1'b0;
        scans(3);
        check("rel_held_early", 32'(KeyHeld), 32'd1);
        cycles(1);
        check("rel_held", 32'(KeyHeld), 32'd0);
        check("rel_key", 32'(Key), 32'h5);
        cycles(SCAN - 1);

        // Bouncing '9' never qualifies
        pressed[10] = 1'b1;
        scans(2);
        pressed[10] = 1'b0;
        scans(1);
        pressed[10] = 1'b1;
        scans(2);
        pressed[10] = 1'b0;
        cycles(2);
        check("bounce_held", 32'(KeyHeld), 32'd0);
        cycles(SCAN - 2);
        scans(2);
        check("bounce_held_end", 32'(KeyHeld), 32'd0);
        check("bounce_key", 32'(Key), 32'h5);

        // '1' and 'D' together: lowest column/row wins
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        sb.push_back('{4'h1, cyc + 3 * SCAN + 1});
        scans(4);
        check("prio_key", 32'(Key), 32'h1);
        check("prio_held", 32'(KeyHeld), 32'd1);
        pressed = 16'h0000;
        scans(4);
        check("prio_rel_held", 32'(KeyHeld), 32'd0);

        // Reset in the middle of debouncing '7'
        pressed[8] = 1'b1;
        scans(2);
        resetSW = 1'b1;
        @(posedge Clock);
        #1;
        resetSW = 1'b0;
        check("rst_key", 32'(Key), 32'd0);
        check("rst_held", 32'(KeyHeld), 32'd0);
        check("rst_col", 32'(Col), 32'h0000_000E);
        sb.push_back('{4'h7, cyc + 3 * SCAN + 1});
        scans(3);
        check("rst_held_early", 32'(KeyHeld), 32'd0);
        cycles(1);
        check("rst_held_after", 32'(KeyHeld), 32'd1);
        check("rst_key_after", 32'(Key), 32'h7);
        cycles(SCAN - 1);
        pressed = 16'h0000;
        scans(4);
        check("end_held", 32'(KeyHeld), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the seven-segment display controller: where the display block strobes anodes one at a time and drives segment data, this block strobes the columns of a 4x4 matrix keypad (Pmod KYPD style) one at a time and reads the rows back. It debounces the result across full scans and presents a 4-bit hex key code with a one-cycle valid pulse. Its output feeds the display path and any datapath that consumes hex entry.

## Interface
- CLK_DIV, default 100000: Clock cycles each column is driven, giving 1 ms per column at 100 MHz. Must be ≥ 4.
- DEBOUNCE_SCANS, default 4: consecutive full scans needed to accept a press or a release. Must be ≥ 2.

- Clock  in  1  system clock; all logic on posedge.
- resetSW  in  1  reset; synchronous and active-high.
- Row  in  4  keypad rows, active-low (pulled up), asynchronous to Clock.
- Col  out  4  column strobe, active-low one-hot.
- Key  out  4  hex code of the last accepted key; holds after release.
- KeyValid  out  1  one-cycle pulse when a new debounced press is accepted.
- KeyHeld  out  1  level, high while the accepted key is debounced-down.

## Operation
- **Row synchronizer:** Row passes through a 2-flop synchronizer before any use.
- **Prescaler:** counts 0..CLK_DIV-1 and wraps. Tick = cycle where count == CLK_DIV-1.
- **Column index:** colIdx, 2 bits, advances 0→1→2→3→0 on each tick. Col = ~(4'b0001 << colIdx).
- **Sampling:** on each tick the synchronized Row is sampled for the current colIdx. A row bit at 0 means the key at (row, colIdx) is down.
- **Scan accumulator:** across one full scan (col0..col3) it keeps the first hit by priority: lowest column first, then lowest row. On the col3 tick it registers scanHit and scanCode, pulses scanDone for one cycle, then clears.
- **Key map, row r / col c:**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **Debounce FSM:** 2-bit state plus counter cnt. It acts only when scanDone is high. "Match" means scanHit && scanCode == cand.
  - IDLE: on hit, cand ← scanCode, cnt ← 1, go to CANDIDATE.
  - CANDIDATE: on match, cnt++. When cnt+1 == DEBOUNCE_SCANS: Key ← cand, pulse KeyValid, go to PRESSED.
  - CANDIDATE: on a hit with a different code, cand ← scanCode and cnt ← 1; stay in CANDIDATE.
  - CANDIDATE: on no hit, go to IDLE.
  - PRESSED: on no match, cnt ← 1 and go to RELEASE. On match, stay.
  - RELEASE: on match, go to PRESSED (glitch absorbed; no KeyValid).
  - RELEASE: on no match, cnt++. When cnt+1 == DEBOUNCE_SCANS, go to IDLE.
  - KeyHeld = (state == PRESSED || state == RELEASE).
- **Changing keys:** pressing a different key without releasing is treated as a release. The new key is accepted only after release debounce followed by press debounce, so each key yields exactly one KeyValid.
- **Reset values:** prescaler 0, colIdx 0, Col = 4'b1110, state IDLE, cnt 0, cand 0, Key = 4'h0, KeyValid = 0, KeyHeld = 0, synchronizer flops all 1.
- **Reset mid-operation:** reset asserted in any state returns everything to reset values on the next edge. No KeyValid is generated during or upon exit from reset.

## Timing
- Scan period is 4·CLK_DIV cycles; each column is held for exactly CLK_DIV cycles.
- A row level must be stable from at least 3 cycles before a tick to be sampled correctly.
- Let cycle T be the col3 tick:
  - scanDone is high in T+1.
  - The FSM updates on the edge ending T+1.
  - KeyValid is high only in T+2; Key and KeyHeld change at T+2.
- Press latency: KeyValid follows the DEBOUNCE_SCANS-th consecutive matching scan, plus 2 cycles.
- Release latency: KeyHeld falls after DEBOUNCE_SCANS consecutive non-matching scans, plus 2 cycles.
- KeyValid is never high for more than 1 cycle. Consecutive pulses are at least 2·DEBOUNCE_SCANS scans apart.
- Prescaler and colIdx wrap freely and are never stalled by the FSM.

## Test plan
All scenarios use CLK_DIV=4, DEBOUNCE_SCANS=3, which gives a 16-cycle scan.

1. **Reset:** assert resetSW for 3 cycles, then release → Col=1110, Key=0, KeyValid=0, KeyHeld=0. Col then steps 1110, 1101, 1011, 0111, each for 4 cycles, repeating.
2. **Clean press:** drive Row[1] low whenever Col[1] is low, for 6 scans (key '5') → exactly one KeyValid pulse, 2 cycles after the 3rd scan's col3 tick. Key=4'h5 and KeyHeld=1 from then on.
3. **Bounce rejection:** key '9' present for 2 scans, absent for 1, present for 2, then absent → KeyValid never asserts and KeyHeld stays 0.
4. **Release:**
   - After '5' is accepted, remove it for 1 scan then restore it → KeyHeld stays 1 and there is no second KeyValid.
   - Then remove it for 3 scans → KeyHeld falls to 0 and Key remains 4'h5.
5. **Priority:** hold '1' (r0,c0) and 'D' (r3,c3) together for 4 scans → a single KeyValid with Key=4'h1.
6. **Reset mid-debounce:** press '7' for 2 scans, pulse resetSW for 1 cycle, keep '7' held → no KeyValid until 3 full scans after reset. Then one pulse with Key=4'h7.
